scc_fetch_unit: RTL

Instruction fetch stage of the SCC core, directly upstream of the instruction/data memory. Owns the program counter and drives the memory's instruction port. Buffers returned instruction words in a small prefetch FIFO and presents them, with their PCs, to decode over a valid/ready handshake. Supports branch redirect (flush), halt, and an out-of-range fetch fault.

---
 rtl/scc_fetch_unit_if.sv | 47 ++++
 rtl/scc_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/scc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// scc_fetch_unit_if
// Bundles the fetch stage's two buses:
//   - instruction memory port : instruction_memory_en/_a (to memory),
//                               instruction_memory_v (word back from memory)
//   - decode handshake        : inst_valid/inst_data/inst_pc (to decode),
//                               inst_ready (from decode)
//   - status                  : fifo_count, fetch_fault
// master = fetch unit side, slave = memory/decode/environment side.
// ---------------------------------------------------------------------------
interface scc_fetch_unit_if #(
    parameter int DEPTH = 4
);
    logic                    instruction_memory_en;
    logic [31:0]             instruction_memory_a;
    logic [31:0]             instruction_memory_v;
    logic                    inst_valid;
    logic                    inst_ready;
    logic [31:0]             inst_data;
    logic [31:0]             inst_pc;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fetch_fault;

    modport master (
        output instruction_memory_en,
        output instruction_memory_a,
        input  instruction_memory_v,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output fifo_count,
        output fetch_fault
    );

    modport slave (
        input  instruction_memory_en,
        input  instruction_memory_a,
        output instruction_memory_v,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  fifo_count,
        input  fetch_fault
    );
endinterface

// File: rtl/scc_fetch_unit.sv
// ---------------------------------------------------------------------------
// scc_fetch_unit
// Instruction fetch stage. Owns the PC, issues one word fetch per cycle to a
// memory with one cycle of read latency, buffers returned words with their
// PCs in a DEPTH-entry prefetch FIFO and offers them to decode over
// valid/ready. Supports redirect (flush + restart), halt and a sticky
// out-of-range fault.
// Ports:
//   mem_Clk        clock, all state on posedge
//   mem_Rst_n      synchronous active-low reset
//   halt_f         level, suspend fetching (FIFO still drains)
//   redirect_valid one-cycle pulse, flush and restart at redirect_pc
//   redirect_pc    new PC (low two bits ignored)
//   bus            memory port, decode handshake and status (master side)
// ---------------------------------------------------------------------------
module scc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] MEM_LIMIT = 32'h0000_FFFC
) (
    input  logic              mem_Clk,
    input  logic              mem_Rst_n,
    input  logic              halt_f,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    scc_fetch_unit_if.master  bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          fault_q, fault_d;
    logic          en_q, en_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic          pop_s;
    logic          push_s;
    logic [CW:0]   occ_s;
    logic          try_issue_s;
    logic          range_ok_s;
    logic          issue_s;
    logic          fault_set_s;
    logic [31:0]   redirect_pc_s;

    // Handshake, credit and issue qualification for this cycle.
    always_comb begin
        pop_s         = (count_q != CW'(1'b0)) && bus.inst_ready;
        // A response is dropped when the stream is flushed or halted.
        push_s        = inflight_q && !redirect_valid && !halt_f;
        // Credit counts the word still in flight so the FIFO never overflows.
        occ_s         = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop_s);
        try_issue_s   = !halt_f && !fault_q && !redirect_valid && (occ_s < DEPTH_W);
        range_ok_s    = (fetch_pc_q <= MEM_LIMIT);
        issue_s       = try_issue_s && range_ok_s;
        fault_set_s   = try_issue_s && !range_ok_s;
        redirect_pc_s = redirect_pc & PC_MASK;
    end

    // Next-state logic for PC, in-flight tracking, fault, enable and FIFO pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue_s;
        inflight_pc_d = inflight_pc_q;
        fault_d       = fault_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_s;
            wr_ptr_d   = AW'(1'b0);
            rd_ptr_d   = AW'(1'b0);
            count_d    = CW'(1'b0);
            if (redirect_pc_s <= MEM_LIMIT) begin
                fault_d = 1'b0;
            end else begin
                fault_d = fault_q;
            end
        end else begin
            if (issue_s) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end else if (halt_f && inflight_q) begin
                // The halted response is discarded, so rewind to refetch it
                // after release; otherwise that PC would be skipped.
                fetch_pc_d = inflight_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            fault_d = fault_q || fault_set_s;

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end

        en_d = !halt_f && !fault_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge mem_Clk) begin
        if (!mem_Rst_n) begin
            fetch_pc_q    <= RESET_PC & PC_MASK;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            fault_q       <= 1'b0;
            en_q          <= 1'b0;
            wr_ptr_q      <= AW'(1'b0);
            rd_ptr_q      <= AW'(1'b0);
            count_q       <= CW'(1'b0);
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
            en_q          <= en_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage: cleared on reset so the head reads zero, written at the tail on push.
    always_ff @(posedge mem_Clk) begin
        if (!mem_Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= bus.instruction_memory_v;
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end else begin
            fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
            fifo_pc_q[wr_ptr_q]   <= fifo_pc_q[wr_ptr_q];
        end
    end

    // Outputs, all taken straight from registers.
    always_comb begin
        bus.instruction_memory_en = en_q;
        bus.instruction_memory_a  = fetch_pc_q;
        bus.inst_valid            = (count_q != CW'(1'b0));
        bus.inst_data             = fifo_data_q[rd_ptr_q];
        bus.inst_pc               = fifo_pc_q[rd_ptr_q];
        bus.fifo_count            = count_q;
        bus.fetch_fault           = fault_q;
    end
endmodule
